serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Parametrised multi-bit subtractor computing diff = a - b - c_in over WIDTH bits.
- Processes DIGIT bits per clock, LSB first, with a registered borrow chain between digits.
- Successor to the single-bit full-subtractor cell: area-cheap sequential datapath with a start/busy/done handshake.
- Used wherever a wide subtract can tolerate WIDTH/DIGIT cycles of latency.

Parameters:
- WIDTH, 8, operand and result width in bits. Must be ≥ 2.
- DIGIT, 1, bits processed per cycle. WIDTH mod DIGIT must be 0; elaboration fails otherwise.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only when busy=0
- a  input  WIDTH  minuend; captured on an accepted start
- b  input  WIDTH  subtrahend; captured on an accepted start
- c_in  input  1  borrow-in; captured on an accepted start
- busy  output  1  high while in RUN
- done  output  1  single-cycle pulse when the result is final
- diff  output  WIDTH  result; valid from done until the next accepted start
- borrow_out  output  1  final borrow; valid with diff

Behaviour:
- States: IDLE, RUN, DONE. Let N = WIDTH/DIGIT.
- Reset (asynchronous, any time including mid-RUN):
  - State goes to IDLE.
  - busy=0, done=0, diff=0, borrow_out=0.
  - Internal operand shift registers, digit counter and borrow register all clear.
  - Any in-flight operation is discarded; no done is produced for it.
- IDLE or DONE, start=1 at edge E0:
  - Capture a, b and c_in into internal registers.
  - Clear diff to 0; the borrow register takes c_in.
  - Next state is RUN; busy=1 from E0.
- RUN: one digit k per edge (k = 0..N-1).
  - The digit result is a[k] - b[k] - borrow, giving DIGIT bits plus a new borrow.
  - The DIGIT result bits are written into diff[k*DIGIT +: DIGIT]; the borrow register updates.
  - At the N-th RUN edge: state goes to DONE, busy=0, done=1, borrow_out takes the final borrow.
- Latency: done is high in the cycle after edge E0+N, i.e. N cycles after start is accepted.
- DONE lasts exactly one cycle. It goes to IDLE at the next edge unless start=1, in which case it goes straight to RUN (back-to-back operation with no bubble).
- done is high only in DONE.
- start while busy=1 is ignored: no capture, no effect on the running operation.
- Final result:
  - diff = (a - b - c_in) mod 2^WIDTH.
  - borrow_out = 1 iff a < b + c_in, with a and b treated as unsigned.
- diff and borrow_out hold their values in IDLE. During RUN, diff shows partial results; consumers must use it only from done onward.
- Input changes on a, b or c_in after capture have no effect.

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), reset value 0.
  - ovf signals two's-complement signed overflow of a - b - c_in: set when a[MSB] != b[MSB] and diff[MSB] != a[MSB].
  - Updated at the same edge as borrow_out; cleared on an accepted start.
  - Held until the next accepted start.
- Undefined: no ovf port and no associated logic; all other behaviour is identical.

Test Plan:
- WIDTH=8, DIGIT=1; a=0x00, b=0x00, c_in=0, start pulse -> done exactly 8 cycles after acceptance, single cycle wide; diff=0x00, borrow_out=0, busy high for 8 cycles.
- WIDTH=8, DIGIT=1:
  - a=0x00, b=0x00, c_in=1 -> diff=0xFF, borrow_out=1.
  - a=0x05, b=0x03, c_in=0 -> diff=0x02, borrow_out=0.
  - a=0xFF, b=0xFF, c_in=1 -> diff=0xFF, borrow_out=1.
- WIDTH=8, DIGIT=4; a=0x10, b=0x01, c_in=0 -> done 2 cycles after acceptance; diff=0x0F, borrow_out=0. Then start asserted during the done cycle with a=0x01, b=0x02 -> accepted without a bubble; diff=0xFF, borrow_out=1.
- Start re-pulsed mid-RUN with different operands -> ignored; first result delivered unchanged with exactly one done pulse.
- rst_n driven low at the 3rd RUN cycle -> busy, done, diff and borrow_out go to 0 immediately. After release, a new start (a=0x09, b=0x04) -> diff=0x05.
- SERIAL_SUBTRACTOR_OVF_EN defined:
  - a=0x80, b=0x01, c_in=0 -> diff=0x7F, borrow_out=0, ovf=1.
  - a=0x7F, b=0xFF -> diff=0x80, borrow_out=1, ovf=1.
  - a=0x05, b=0x03 -> ovf=0.

Source files
------------

// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: diff = a - b - c_in, DIGIT bits per cycle, LSB first.
// Optional signed-overflow output enabled by defining SERIAL_SUBTRACTOR_OVF_EN.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned N     = WIDTH / DIGIT;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    if (WIDTH < 2) begin : g_width_chk
        $error("serial_subtractor: WIDTH must be >= 2");
    end
    if (DIGIT == 0 || (WIDTH % DIGIT) != 0) begin : g_digit_chk
        $error("serial_subtractor: WIDTH must be a non-zero multiple of DIGIT");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_out_q, borrow_out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    // Operand sign bits are shifted out of a_q/b_q, so keep them separately.
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             ovf_q, ovf_d;
`endif

    logic [DIGIT:0]   dsub;
    logic             last;

    always_comb begin
        state_d      = state_q;
        a_d          = a_q;
        b_d          = b_q;
        cnt_d        = cnt_q;
        borrow_d     = borrow_q;
        diff_d       = diff_q;
        borrow_out_d = borrow_out_q;
        busy_d       = busy_q;
        done_d       = done_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        a_msb_d      = a_msb_q;
        b_msb_d      = b_msb_q;
        ovf_d        = ovf_q;
`endif
        // Top bit of the widened difference is the digit borrow.
        dsub = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]} - {{DIGIT{1'b0}}, borrow_q};
        last = (cnt_q == CNT_W'(N - 1));

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                done_d  = 1'b0;
                if (start) begin
                    state_d  = RUN;
                    a_d      = a;
                    b_d      = b;
                    borrow_d = c_in;
                    cnt_d    = '0;
                    diff_d   = '0;
                    busy_d   = 1'b1;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                    a_msb_d  = a[WIDTH-1];
                    b_msb_d  = b[WIDTH-1];
                    ovf_d    = 1'b0;
`endif
                end
            end
            RUN: begin
                a_d      = a_q >> DIGIT;
                b_d      = b_q >> DIGIT;
                borrow_d = dsub[DIGIT];
                cnt_d    = cnt_q + CNT_W'(1);
                for (int unsigned k = 0; k < N; k++) begin
                    if (cnt_q == CNT_W'(k)) begin
                        diff_d[k*DIGIT +: DIGIT] = dsub[DIGIT-1:0];
                    end
                end
                if (last) begin
                    state_d      = DONE;
                    cnt_d        = '0;
                    busy_d       = 1'b0;
                    done_d       = 1'b1;
                    borrow_out_d = dsub[DIGIT];
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                    ovf_d        = (a_msb_q != b_msb_q) && (dsub[DIGIT-1] != a_msb_q);
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            cnt_q        <= '0;
            borrow_q     <= 1'b0;
            diff_q       <= '0;
            borrow_out_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            a_msb_q      <= 1'b0;
            b_msb_q      <= 1'b0;
            ovf_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            cnt_q        <= cnt_d;
            borrow_q     <= borrow_d;
            diff_q       <= diff_d;
            borrow_out_q <= borrow_out_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
            a_msb_q      <= a_msb_d;
            b_msb_q      <= b_msb_d;
            ovf_q        <= ovf_d;
`endif
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign diff       = diff_q;
    assign borrow_out = borrow_out_q;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    assign ovf        = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: DIGIT=1 and DIGIT=4 instances, WIDTH=8.
module tb_serial_subtractor;

    typedef struct {
        logic [7:0] diff;
        logic       bor;
        logic       ovf;
        int         due;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    logic       d1_start, d1_c_in, d1_busy, d1_done, d1_borrow_out;
    logic [7:0] d1_a, d1_b, d1_diff;
    logic       d4_start, d4_c_in, d4_busy, d4_done, d4_borrow_out;
    logic [7:0] d4_a, d4_b, d4_diff;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    logic       d1_ovf, d4_ovf;
`endif

    exp_t q1[$];
    exp_t q4[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_subtractor #(.WIDTH(8), .DIGIT(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .start(d1_start), .a(d1_a), .b(d1_b), .c_in(d1_c_in),
        .busy(d1_busy), .done(d1_done), .diff(d1_diff), .borrow_out(d1_borrow_out)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        , .ovf(d1_ovf)
`endif
    );

    serial_subtractor #(.WIDTH(8), .DIGIT(4)) u_d4 (
        .clk(clk), .rst_n(rst_n), .start(d4_start), .a(d4_a), .b(d4_b), .c_in(d4_c_in),
        .busy(d4_busy), .done(d4_done), .diff(d4_diff), .borrow_out(d4_borrow_out)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        , .ovf(d4_ovf)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Monitors: every done pulse must match the oldest outstanding result.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && d1_done === 1'b1) begin
            if (q1.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL d1_spurious_done: got done=1 with no result outstanding, required done=0");
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("d1_latency_cycle", cyc, e.due);
                check("d1_diff", {24'd0, d1_diff}, {24'd0, e.diff});
                check("d1_borrow_out", {31'd0, d1_borrow_out}, {31'd0, e.bor});
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                check("d1_ovf", {31'd0, d1_ovf}, {31'd0, e.ovf});
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n === 1'b1 && d4_done === 1'b1) begin
            if (q4.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL d4_spurious_done: got done=1 with no result outstanding, required done=0");
            end else begin
                exp_t e;
                e = q4.pop_front();
                check("d4_latency_cycle", cyc, e.due);
                check("d4_diff", {24'd0, d4_diff}, {24'd0, e.diff});
                check("d4_borrow_out", {31'd0, d4_borrow_out}, {31'd0, e.bor});
`ifdef SERIAL_SUBTRACTOR_OVF_EN
                check("d4_ovf", {31'd0, d4_ovf}, {31'd0, e.ovf});
`endif
            end
        end
    end

    // Drives one start pulse; returns 1 time unit after the accepting edge.
    task automatic issue(input int which, input logic [7:0] av, input logic [7:0] bv, input logic cv,
                         input bit push, input logic [7:0] ed, input logic eb, input logic eo);
        exp_t e;
        @(posedge clk); #1;
        if (which == 1) begin
            d1_start = 1'b1; d1_a = av; d1_b = bv; d1_c_in = cv;
        end else begin
            d4_start = 1'b1; d4_a = av; d4_b = bv; d4_c_in = cv;
        end
        @(posedge clk); #1;
        d1_start = 1'b0;
        d4_start = 1'b0;
        if (push) begin
            e.diff = ed; e.bor = eb; e.ovf = eo;
            e.due  = cyc + ((which == 1) ? 8 : 2);
            if (which == 1) q1.push_back(e);
            else q4.push_back(e);
        end
    endtask

    task automatic drain(input int which);
        for (int i = 0; i < 40; i++) begin
            if (((which == 1) ? q1.size() : q4.size()) == 0) break;
            @(posedge clk); #2;
        end
        check((which == 1) ? "d1_result_timeout_outstanding" : "d4_result_timeout_outstanding",
              (which == 1) ? q1.size() : q4.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        exp_t e;
        rst_n = 1'b0;
        d1_start = 1'b0; d1_a = '0; d1_b = '0; d1_c_in = 1'b0;
        d4_start = 1'b0; d4_a = '0; d4_b = '0; d4_c_in = 1'b0;
        #12;
        check("reset_d1_busy", {31'd0, d1_busy}, 0);
        check("reset_d1_done", {31'd0, d1_done}, 0);
        check("reset_d1_diff", {24'd0, d1_diff}, 0);
        check("reset_d1_borrow_out", {31'd0, d1_borrow_out}, 0);
        check("reset_d4_diff", {24'd0, d4_diff}, 0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        check("reset_d1_ovf", {31'd0, d1_ovf}, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // 0 - 0 - 0 with busy/done timing checked cycle by cycle.
        issue(1, 8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            check("d1_busy_in_run", {31'd0, d1_busy}, 1);
            @(posedge clk); #1;
        end
        check("d1_busy_after_run", {31'd0, d1_busy}, 0);
        check("d1_done_at_n", {31'd0, d1_done}, 1);
        @(posedge clk); #1;
        check("d1_done_single_cycle", {31'd0, d1_done}, 0);
        drain(1);

        issue(1, 8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0); drain(1);
        issue(1, 8'h05, 8'h03, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0); drain(1);
        issue(1, 8'hFF, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0); drain(1);

        // Start re-pulsed mid-run with different operands must be ignored.
        issue(1, 8'h3C, 8'h1A, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        d1_start = 1'b1; d1_a = 8'hFF; d1_b = 8'h00; d1_c_in = 1'b1;
        @(posedge clk); #1;
        d1_start = 1'b0;
        drain(1);
        repeat (10) @(posedge clk);
        #1;
        check("d1_diff_held_idle", {24'd0, d1_diff}, 32'h22);

`ifdef SERIAL_SUBTRACTOR_OVF_EN
        issue(1, 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b1); drain(1);
        issue(1, 8'h7F, 8'hFF, 1'b0, 1'b1, 8'h80, 1'b1, 1'b1); drain(1);
        issue(1, 8'h05, 8'h03, 1'b0, 1'b1, 8'h02, 1'b0, 1'b0); drain(1);
`endif

        // DIGIT=4: back-to-back start during the done cycle.
        @(posedge clk); #1;
        d4_start = 1'b1; d4_a = 8'h10; d4_b = 8'h01; d4_c_in = 1'b0;
        @(posedge clk); #1;
        d4_start = 1'b0;
        e.diff = 8'h0F; e.bor = 1'b0; e.ovf = 1'b0; e.due = cyc + 2;
        q4.push_back(e);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("d4_done_before_b2b", {31'd0, d4_done}, 1);
        d4_start = 1'b1; d4_a = 8'h01; d4_b = 8'h02; d4_c_in = 1'b0;
        @(posedge clk); #1;
        d4_start = 1'b0;
        check("d4_busy_b2b_no_bubble", {31'd0, d4_busy}, 1);
        e.diff = 8'hFF; e.bor = 1'b1; e.ovf = 1'b0; e.due = cyc + 2;
        q4.push_back(e);
        drain(4);

        // Asynchronous reset in the third RUN cycle discards the operation.
        issue(1, 8'h55, 8'h22, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("midrun_reset_busy", {31'd0, d1_busy}, 0);
        check("midrun_reset_done", {31'd0, d1_done}, 0);
        check("midrun_reset_diff", {24'd0, d1_diff}, 0);
        check("midrun_reset_borrow_out", {31'd0, d1_borrow_out}, 0);
        check("midrun_reset_d4_diff", {24'd0, d4_diff}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        issue(1, 8'h09, 8'h04, 1'b0, 1'b1, 8'h05, 1'b0, 1'b0);
        drain(1);
        repeat (4) @(posedge clk);
        #1;
        check("d1_final_queue_empty", q1.size(), 0);
        check("d4_final_queue_empty", q4.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
